// File: rtl/clk_pkg.sv
// Shared types and constants for the fractional clock-enable generator:
// control FSM states, channel-index width helper and standard phase increments.
package clk_pkg;

    typedef enum logic [1:0] {
        S_RST    = 2'd0,
        S_SETTLE = 2'd1,
        S_RUN    = 2'd2
    } ctrl_state_t;

    function automatic int ch_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Increments for clk_in = 27 MHz, ACC_W = 32; the NTSC master clock is 6x the subcarrier.
    localparam logic [31:0] INC_NTSC_SC     = 32'd569408542;
    localparam logic [31:0] INC_NTSC_MASTER = 32'd3416451252;
    localparam logic [31:0] INC_USB_12M     = 32'd1908874354;

endpackage

// File: rtl/frac_clken_ch.sv
// One fractional clock-enable channel: phase accumulator, increment register
// and registered carry strobe; the increment changes only when commit is high.
module frac_clken_ch #(
    parameter int               ACC_W    = 32,
    parameter logic [ACC_W-1:0] INIT_INC = '0
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sync_req,
    input  logic             commit,
    input  logic [ACC_W-1:0] commit_inc,
    input  logic             run,
    output logic             ce,
    output logic             phase_msb,
    output logic             carry,
    output logic             inc_zero
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc;
    logic [ACC_W-1:0] sum;
    logic             strobe;

    assign {carry, sum} = {1'b0, acc} + {1'b0, inc};

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            acc    <= '0;
            inc    <= INIT_INC;
            strobe <= 1'b0;
        end else begin
            // Realignment wins over the running phase and swallows that cycle's strobe.
            acc    <= sync_req ? '0 : sum;
            strobe <= carry & ~sync_req;
            if (commit) begin
                inc <= commit_inc;
            end
        end
    end

    assign ce        = strobe & run;
    assign phase_msb = acc[ACC_W-1];
    assign inc_zero  = (inc == '0);

endmodule

// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator with a single-slot increment
// staging register, glitch-free commits on channel wrap, and a settle/ready FSM.
module frac_clken_gen
    import clk_pkg::*;
#(
    parameter int                      NUM_CH        = 3,
    parameter int                      ACC_W         = 32,
    parameter int                      SETTLE_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INIT_INC      = '0,
    localparam int                     CH_W          = ch_width(NUM_CH)
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_chan,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              sync_req,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] phase_msb,
    output logic              ready
);

    localparam int              CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CH_W:0]   NUM_CH_L = (CH_W + 1)'(NUM_CH);

    logic              stg_pend;
    logic [CH_W-1:0]   stg_chan;
    logic [ACC_W-1:0]  stg_inc;
    logic              accept;
    logic              chan_ok;
    logic [NUM_CH-1:0] carry;
    logic [NUM_CH-1:0] inc_zero;
    logic [NUM_CH-1:0] commit;
    logic              commit_any;
    logic              run;

    ctrl_state_t       state;
    ctrl_state_t       state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;

    assign cfg_ready = ~stg_pend;
    assign accept    = cfg_valid & cfg_ready;
    assign chan_ok   = ({1'b0, cfg_chan} < NUM_CH_L);

    // Out-of-range writes are taken off the bus but never marked pending.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            stg_pend <= 1'b0;
            stg_chan <= '0;
            stg_inc  <= '0;
        end else begin
            if (commit_any) begin
                stg_pend <= 1'b0;
            end
            if (accept) begin
                stg_pend <= chan_ok;
                stg_chan <= cfg_chan;
                stg_inc  <= cfg_inc;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // A stalled channel never wraps, so it may take the new rate immediately.
        assign commit[g] = stg_pend && (stg_chan == CH_W'(g)) && (carry[g] || inc_zero[g]);

        frac_clken_ch #(
            .ACC_W    (ACC_W),
            .INIT_INC (INIT_INC[g*ACC_W +: ACC_W])
        ) u_ch (
            .clk_in     (clk_in),
            .rst_n      (rst_n),
            .sync_req   (sync_req),
            .commit     (commit[g]),
            .commit_inc (stg_inc),
            .run        (run),
            .ce         (ce_out[g]),
            .phase_msb  (phase_msb[g]),
            .carry      (carry[g]),
            .inc_zero   (inc_zero[g])
        );
    end

    assign commit_any = |commit;

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state <= S_RST;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            S_RST: begin
                state_nx = S_SETTLE;
                cnt_nx   = '0;
            end
            S_SETTLE: begin
                if (commit_any) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nx = S_RUN;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (commit_any) begin
                    state_nx = S_SETTLE;
                    cnt_nx   = '0;
                end
            end
            default: begin
                state_nx = S_RST;
                cnt_nx   = '0;
            end
        endcase
    end

    assign run   = (state == S_RUN);
    assign ready = run;

endmodule

// File: tb/tb_frac_clken_gen.sv
// Bench for frac_clken_gen (ACC_W=8, NUM_CH=2, SETTLE_CYCLES=4): directed
// scenarios plus randomized traffic, all checked against an arithmetic model.
module tb_frac_clken_gen;

    localparam int          ACC_W  = 8;
    localparam int          NUM_CH = 2;
    localparam int          SETTLE = 4;
    localparam int          MODV   = 256;
    localparam logic [15:0] INIT   = 16'h0040;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [0:0] cfg_chan;
    logic [7:0] cfg_inc;
    logic       sync_req;
    logic [1:0] ce_out;
    logic [1:0] phase_msb;
    logic       ready;

    int total = 0;
    int bad   = 0;

    always #5 clk_in = ~clk_in;

    frac_clken_gen #(
        .NUM_CH        (NUM_CH),
        .ACC_W         (ACC_W),
        .SETTLE_CYCLES (SETTLE),
        .INIT_INC      (INIT)
    ) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_inc   (cfg_inc),
        .sync_req  (sync_req),
        .ce_out    (ce_out),
        .phase_msb (phase_msb),
        .ready     (ready)
    );

    // Reference model: integer phases, a countdown of settle cycles left, a pending slot.
    int m_acc [NUM_CH];
    int m_inc [NUM_CH];
    bit m_stb [NUM_CH];
    bit m_pend;
    int m_pch;
    int m_pinc;
    bit m_inrst;
    int m_settle;

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] = 0;
            m_inc[i] = int'(INIT[i*ACC_W +: ACC_W]);
            m_stb[i] = 1'b0;
        end
        m_pend   = 1'b0;
        m_inrst  = 1'b1;
        m_settle = 0;
    endfunction

    function automatic void model_edge();
        bit committed;
        bit take;
        int s;
        bit c;
        if (!rst_n) begin
            model_reset();
            return;
        end
        committed = 1'b0;
        take      = !m_pend && cfg_valid;
        for (int i = 0; i < NUM_CH; i++) begin
            s = m_acc[i] + m_inc[i];
            c = (s >= MODV);
            m_stb[i] = c && !sync_req;
            m_acc[i] = sync_req ? 0 : s % MODV;
            if (m_pend && m_pch == i && (c || m_inc[i] == 0)) begin
                m_inc[i]  = m_pinc;
                committed = 1'b1;
            end
        end
        if (m_inrst) begin
            m_inrst  = 1'b0;
            m_settle = SETTLE;
        end else if (committed) begin
            m_settle = SETTLE;
        end else if (m_settle > 0) begin
            m_settle--;
        end
        if (committed) m_pend = 1'b0;
        if (take) begin
            m_pend = (int'(cfg_chan) < NUM_CH);
            m_pch  = int'(cfg_chan);
            m_pinc = int'(cfg_inc);
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        bit       r;
        logic [1:0] e_ce;
        logic [1:0] e_msb;
        r = !m_inrst && (m_settle == 0);
        for (int i = 0; i < NUM_CH; i++) begin
            e_ce[i]  = m_stb[i] && r;
            e_msb[i] = (m_acc[i] >= MODV / 2);
        end
        chk("model_ce_out", ce_out, e_ce);
        chk("model_phase_msb", phase_msb, e_msb);
        chk("model_ready", ready, r);
        chk("model_cfg_ready", cfg_ready, !m_pend);
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk_in);
        @(negedge clk_in);
        check_model();
    endtask

    task automatic write(input int ch, input int inc, output int waited);
        bit rdy;
        cfg_valid = 1'b1;
        cfg_chan  = ch[0:0];
        cfg_inc   = inc[7:0];
        waited    = 0;
        forever begin
            rdy = cfg_ready;
            cycle();
            if (rdy) break;
            waited++;
            if (waited > 300) begin
                chk("write_timeout", waited, 0);
                break;
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int limit);
        int g = 0;
        while (!ready && g < limit) begin
            cycle();
            g++;
        end
        if (!ready) chk(tag, ready, 1);
    endtask

    task automatic count_ce(input int n, output int c0, output int c1, output int badgap0, input int gap);
        int last = -1;
        c0 = 0;
        c1 = 0;
        badgap0 = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            if (ce_out[0]) begin
                if (last >= 0 && k - last != gap) badgap0++;
                last = k;
                c0++;
            end
            if (ce_out[1]) c1++;
        end
    endtask

    task automatic reset_latency(input string tag);
        int n = 0;
        while (n < 20) begin
            cycle();
            n++;
            if (ready) break;
        end
        chk(tag, n, SETTLE + 1);
    endtask

    initial begin
        int w, c0, c1, bg, low, g, d, busy;
        bit rdy;

        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_inc   = '0;
        sync_req  = 1'b0;
        model_reset();
        repeat (3) cycle();
        chk("rst_ce_out", ce_out, 0);
        chk("rst_phase_msb", phase_msb, 0);
        chk("rst_ready", ready, 0);
        chk("rst_cfg_ready", cfg_ready, 1);

        // Release reset; ch0 runs at 64/256, ch1 idle.
        rst_n = 1'b1;
        reset_latency("ready_latency");
        count_ce(16, c0, c1, bg, 4);
        chk("ch0_strobes_16", c0, 4);
        chk("ch0_gap4", bg, 0);
        chk("ch1_idle", c1, 0);

        // ch1 -> 96: idle channel commits at once, settle lasts SETTLE cycles.
        write(1, 96, w);
        chk("cfg_ready_busy", cfg_ready, 0);
        low = 0;
        g   = 0;
        while (ready && g < 10) begin cycle(); g++; end
        while (!ready && g < 40) begin low++; cycle(); g++; end
        chk("settle_len", low, SETTLE);
        count_ce(8, c0, c1, bg, 4);
        chk("ch1_3_per_8", c1, 3);
        count_ce(16, c0, c1, bg, 4);
        chk("ch1_6_per_16", c1, 6);

        // ch0 -> 128 one cycle past its wrap: commit waits for the next wrap.
        g = 0;
        while (!ce_out[0] && g < 8) begin cycle(); g++; end
        cycle();
        write(0, 128, w);
        d = 0;
        while (ready && d < 10) begin cycle(); d++; end
        chk("commit_wait", d, 2);
        wait_ready("ready_after_ch0", 20);
        count_ce(12, c0, c1, bg, 2);
        chk("ch0_strobes_fast", c0, 6);
        chk("ch0_gap2", bg, 0);

        // Back-to-back writes: second one stalls until the first commits.
        write(1, 64, w);
        cfg_valid = 1'b1;
        cfg_chan  = 1'b0;
        cfg_inc   = 8'd64;
        chk("cfg_ready_pending", cfg_ready, 0);
        busy = 0;
        while (!cfg_ready && busy < 300) begin cycle(); busy++; end
        chk("ready_at_slot_free", ready, 0);
        cycle();
        cfg_valid = 1'b0;
        chk("second_accepted", cfg_ready, 0);
        wait_ready("ready_after_pair", 30);
        count_ce(16, c0, c1, bg, 4);
        chk("pair_ch0_strobes", c0, 4);
        chk("pair_ch1_strobes", c1, 4);

        // sync_req on the edge where ch0 would wrap: strobe suppressed, phases realigned.
        g = 0;
        while (!ce_out[0] && g < 8) begin cycle(); g++; end
        repeat (3) cycle();
        sync_req = 1'b1;
        cycle();
        sync_req = 1'b0;
        chk("sync_ce_out", ce_out, 0);
        chk("sync_phase_msb", phase_msb, 0);
        d = 0;
        while (!ce_out[0] && d < 20) begin cycle(); d++; end
        chk("sync_first_strobe", d, MODV / 64);
        chk("sync_ch1_aligned", ce_out[1], 1);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("sync_equal", ce_out[0], ce_out[1]);
        end

        // Reset mid-settle with a slow-committing write pending.
        write(0, 128, w);
        write(1, 1, w);
        write(1, 200, w);
        chk("pre_rst_ready", ready, 0);
        chk("pre_rst_pending", cfg_ready, 0);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("mid_rst_ce_out", ce_out, 0);
        chk("mid_rst_phase_msb", phase_msb, 0);
        chk("mid_rst_ready", ready, 0);
        chk("mid_rst_cfg_ready", cfg_ready, 1);
        reset_latency("ready_latency_2");
        count_ce(24, c0, c1, bg, 4);
        chk("post_rst_ch0", c0, 6);
        chk("post_rst_ch0_gap", bg, 0);
        chk("post_rst_ch1", c1, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            rdy = cfg_ready;
            if (!cfg_valid && $urandom_range(7) == 0) begin
                cfg_valid = 1'b1;
                cfg_chan  = 1'($urandom_range(1));
                case ($urandom_range(3))
                    0:       cfg_inc = 8'd0;
                    1:       cfg_inc = 8'(128 + $urandom_range(127));
                    default: cfg_inc = 8'($urandom_range(255));
                endcase
            end
            sync_req = ($urandom_range(19) == 0);
            rst_n    = !($urandom_range(199) == 0);
            cycle();
            if (cfg_valid && rdy) cfg_valid = 1'b0;
        end
        sync_req  = 1'b0;
        rst_n     = 1'b1;
        cfg_valid = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
